// File: rtl/mem_perf_pkg.sv
// Shared types and constants for the memory-stage performance monitor.
package mem_perf_pkg;

    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] SAT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } perf_state_e;

endpackage

// File: rtl/sat_counter32.sv
// Saturating event counter with synchronous clear; holds at SAT_MAX instead of wrapping.
module sat_counter32
    import mem_perf_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && (count_q != SAT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_perf_monitor.sv
// Kernel-region cycle timer and store-activity statistics fed from the CPU memory stage.
// Define MEM_PERF_RANGE_EN to build the min/max store-address trackers.
module mem_perf_monitor
    import mem_perf_pkg::*;
#(
    parameter logic [31:0] START_PC     = 32'h0000_1054,
    parameter logic [31:0] LAST_ADDR    = 32'h0002_FFFC,
    parameter logic [31:0] WIN_LO       = 32'h0002_0100,
    parameter logic [31:0] WIN_HI       = 32'h0002_FFFC,
    parameter int unsigned DRAIN_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [31:0] fetch_pc,
    input  logic        mem_is_store,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_pc,
    input  logic        halt_req,
    output logic        done,
    output logic        loop_valid,
    output logic [31:0] loop_cycles,
    output logic [31:0] total_cycles,
    output logic [31:0] store_cycles,
    output logic [31:0] store_events,
    output logic [31:0] win_events,
    output logic [31:0] last_store_pc,
    output logic [31:0] min_addr,
    output logic [31:0] max_addr
);

    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

    perf_state_e      state_q;
    perf_state_e      state_d;
    logic [CNT_W-1:0] drain_cnt_q;
    logic [CNT_W-1:0] drain_cnt_d;
    logic [CNT_W-1:0] start_cycle_q;
    logic [CNT_W-1:0] start_cycle_d;
    logic [CNT_W-1:0] loop_cycles_q;
    logic [CNT_W-1:0] loop_cycles_d;
    logic             loop_valid_q;
    logic             loop_valid_d;
    logic             done_q;
    logic             done_d;
    logic             prev_store_q;
    logic             prev_store_d;
    logic [31:0]      last_store_pc_q;
    logic [31:0]      last_store_pc_d;

    logic             last_addr_hit;
    logic             stat_active;
    logic             store_edge;
    logic             in_window;

    assign last_addr_hit = mem_is_store && (mem_addr == LAST_ADDR);
    assign stat_active   = (state_q == RUN) || (state_q == DRAIN);
    assign store_edge    = mem_is_store && !prev_store_q;
    assign in_window     = (mem_addr >= WIN_LO) && (mem_addr <= WIN_HI);

    // A LAST_ADDR store outranks a simultaneous halt so the loop measurement is kept.
    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        start_cycle_d = start_cycle_q;
        loop_cycles_d = loop_cycles_q;
        loop_valid_d  = loop_valid_q;
        done_d        = done_q;
        if (clear) begin
            state_d       = IDLE;
            drain_cnt_d   = '0;
            start_cycle_d = '0;
            loop_cycles_d = '0;
            loop_valid_d  = 1'b0;
            done_d        = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (halt_req) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end else if (fetch_pc == START_PC) begin
                        state_d       = RUN;
                        start_cycle_d = total_cycles;
                    end
                end
                RUN: begin
                    if (last_addr_hit) begin
                        state_d       = DRAIN;
                        drain_cnt_d   = DRAIN_LOAD;
                        loop_cycles_d = total_cycles - start_cycle_q + CNT_W'(1);
                        loop_valid_d  = 1'b1;
                    end else if (halt_req) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            drain_cnt_q   <= '0;
            start_cycle_q <= '0;
            loop_cycles_q <= '0;
            loop_valid_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            start_cycle_q <= start_cycle_d;
            loop_cycles_q <= loop_cycles_d;
            loop_valid_q  <= loop_valid_d;
            done_q        <= done_d;
        end
    end

    // prev_store tracks the strobe in every state so edge detection is exact on RUN entry.
    always_comb begin
        prev_store_d    = mem_is_store;
        last_store_pc_d = last_store_pc_q;
        if (clear) begin
            prev_store_d    = 1'b0;
            last_store_pc_d = SAT_MAX;
        end else if (stat_active && mem_is_store) begin
            last_store_pc_d = mem_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_store_q    <= 1'b0;
            last_store_pc_q <= SAT_MAX;
        end else begin
            prev_store_q    <= prev_store_d;
            last_store_pc_q <= last_store_pc_d;
        end
    end

    sat_counter32 u_total_cycles (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .en    (state_q != DONE),
        .count (total_cycles)
    );

    sat_counter32 u_store_cycles (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .en    (stat_active && mem_is_store),
        .count (store_cycles)
    );

    sat_counter32 u_store_events (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .en    (stat_active && store_edge),
        .count (store_events)
    );

    sat_counter32 u_win_events (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .en    (stat_active && store_edge && in_window),
        .count (win_events)
    );

`ifdef MEM_PERF_RANGE_EN
    logic [31:0] min_addr_q;
    logic [31:0] min_addr_d;
    logic [31:0] max_addr_q;
    logic [31:0] max_addr_d;

    always_comb begin
        min_addr_d = min_addr_q;
        max_addr_d = max_addr_q;
        if (clear) begin
            min_addr_d = SAT_MAX;
            max_addr_d = '0;
        end else if (stat_active && store_edge) begin
            if (mem_addr < min_addr_q) begin
                min_addr_d = mem_addr;
            end
            if (mem_addr > max_addr_q) begin
                max_addr_d = mem_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min_addr_q <= SAT_MAX;
            max_addr_q <= '0;
        end else begin
            min_addr_q <= min_addr_d;
            max_addr_q <= max_addr_d;
        end
    end

    assign min_addr = min_addr_q;
    assign max_addr = max_addr_q;
`else
    assign min_addr = SAT_MAX;
    assign max_addr = '0;
`endif

    assign done          = done_q;
    assign loop_valid    = loop_valid_q;
    assign loop_cycles   = loop_cycles_q;
    assign last_store_pc = last_store_pc_q;

endmodule
